// File: rtl/lms_pkg.sv
// Shared state encoding and default sizing for the LMS FIFO-pair scheduler.
package lms_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } lms_state_e;

   localparam int LMS_DW        = 16;
   localparam int LMS_FRAME_LEN = 1024;

endpackage

// File: rtl/lms_fifo_pair_sched_if.sv
// Bundle of the two prefetch-FIFO read ports and the paired output toward the LMS core.
interface lms_fifo_pair_sched_if
   import lms_pkg::*;
#(
   parameter int DW = LMS_DW
) ();

   logic          ref_rd_vld;
   logic [DW-1:0] ref_rd_data;
   logic          ref_rd_en;
   logic          des_rd_vld;
   logic [DW-1:0] des_rd_data;
   logic          des_rd_en;
   logic          out_vld;
   logic          out_rdy;
   logic [DW-1:0] out_ref;
   logic [DW-1:0] out_des;
   logic          out_last;

   // The scheduler is the master: it pops the FIFOs and drives the pair.
   modport master (
      input  ref_rd_vld, ref_rd_data, des_rd_vld, des_rd_data, out_rdy,
      output ref_rd_en, des_rd_en, out_vld, out_ref, out_des, out_last
   );

   modport slave (
      output ref_rd_vld, ref_rd_data, des_rd_vld, des_rd_data, out_rdy,
      input  ref_rd_en, des_rd_en, out_vld, out_ref, out_des, out_last
   );

endinterface

// File: rtl/lms_pair_outreg.sv
// One-entry output register holding a ref/des pair; a load in the handshake cycle gives 1 pair/cycle.
module lms_pair_outreg
   import lms_pkg::*;
#(
   parameter int DATA_WIDTH = LMS_DW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_i,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] ref_i,
   input  logic [DATA_WIDTH-1:0] des_i,
   input  logic                  last_i,
   input  logic                  rdy_i,
   output logic                  vld_o,
   output logic [DATA_WIDTH-1:0] ref_o,
   output logic [DATA_WIDTH-1:0] des_o,
   output logic                  last_o
);

   logic                  vld_q, vld_d;
   logic                  last_q, last_d;
   logic [DATA_WIDTH-1:0] refData_q, refData_d;
   logic [DATA_WIDTH-1:0] desData_q, desData_d;

   // Clear (flush) beats a load so an in-flight pair is dropped.
   always_comb begin
      vld_d     = vld_q;
      last_d    = last_q;
      refData_d = refData_q;
      desData_d = desData_q;
      if (clear_i) begin
         vld_d  = 1'b0;
         last_d = 1'b0;
      end else if (load_i) begin
         vld_d     = 1'b1;
         last_d    = last_i;
         refData_d = ref_i;
         desData_d = des_i;
      end else if (vld_q && rdy_i) begin
         vld_d  = 1'b0;
         last_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q     <= 1'b0;
         last_q    <= 1'b0;
         refData_q <= '0;
         desData_q <= '0;
      end else begin
         vld_q     <= vld_d;
         last_q    <= last_d;
         refData_q <= refData_d;
         desData_q <= desData_d;
      end
   end

   assign vld_o  = vld_q;
   assign last_o = last_q;
   assign ref_o  = refData_q;
   assign des_o  = desData_q;

endmodule

// File: rtl/lms_fifo_pair_sched.sv
// Lockstep read scheduler for the ref/des prefetch FIFOs: pairs samples, frames them, flushes, flags skew.
module lms_fifo_pair_sched
   import lms_pkg::*;
#(
   parameter int DATA_WIDTH  = LMS_DW,
   parameter int FRAME_LEN   = LMS_FRAME_LEN,
   parameter int CNT_WIDTH   = 10,
   parameter int STALL_MAX   = 255,
   parameter int STALL_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 flush_i,
   input  logic                 err_clr_i,
   output logic                 busy_o,
   output logic                 frame_done_o,
   output logic                 skew_err_o,
   lms_fifo_pair_sched_if.master sched
);

   lms_state_e             state_q, state_d;
   logic [CNT_WIDTH-1:0]   sampleCnt_q, sampleCnt_d;
   logic [STALL_WIDTH-1:0] stallCnt_q, stallCnt_d;
   logic                   skewErr_q, skewErr_d;
   logic                   frameDone_q, frameDone_d;

   logic pop, refRdEn, desRdEn;
   logic outVld, outLast, handshakeLast, cntAtLast, oneVld;

   assign cntAtLast     = (sampleCnt_q == CNT_WIDTH'(FRAME_LEN - 1));
   assign handshakeLast = outVld && sched.out_rdy && outLast;
   assign oneVld        = sched.ref_rd_vld ^ sched.des_rd_vld;

   // Once the last pair of a frame is loaded, popping waits for its handshake.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      refRdEn = 1'b0;
      desRdEn = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = RUN;
         end
         RUN: begin
            pop = !flush_i && sched.ref_rd_vld && sched.des_rd_vld &&
                  (!outVld || sched.out_rdy) && !(outVld && outLast);
            refRdEn = pop;
            desRdEn = pop;
            if (handshakeLast) state_d = IDLE;
         end
         FLUSH: begin
            refRdEn = sched.ref_rd_vld;
            desRdEn = sched.des_rd_vld;
            if (!sched.ref_rd_vld && !sched.des_rd_vld && !outVld) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = FLUSH;
   end

   // Skew set wins over err_clr in the same cycle.
   always_comb begin
      sampleCnt_d = sampleCnt_q;
      if (flush_i || state_q == FLUSH) sampleCnt_d = '0;
      else if (pop) sampleCnt_d = cntAtLast ? '0 : sampleCnt_q + 1'b1;
      stallCnt_d  = (state_q == RUN && oneVld) ? stallCnt_q + 1'b1 : '0;
      skewErr_d   = skewErr_q;
      if (err_clr_i) skewErr_d = 1'b0;
      if (state_q == RUN && stallCnt_q == STALL_WIDTH'(STALL_MAX)) skewErr_d = 1'b1;
      frameDone_d = handshakeLast;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sampleCnt_q <= '0;
         stallCnt_q  <= '0;
         skewErr_q   <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sampleCnt_q <= sampleCnt_d;
         stallCnt_q  <= stallCnt_d;
         skewErr_q   <= skewErr_d;
         frameDone_q <= frameDone_d;
      end
   end

   lms_pair_outreg #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_outreg (
      .clk    (clk),
      .rst    (rst),
      .clear_i(flush_i),
      .load_i (pop),
      .ref_i  (sched.ref_rd_data),
      .des_i  (sched.des_rd_data),
      .last_i (cntAtLast),
      .rdy_i  (sched.out_rdy),
      .vld_o  (outVld),
      .ref_o  (sched.out_ref),
      .des_o  (sched.out_des),
      .last_o (outLast)
   );

   assign sched.out_vld   = outVld;
   assign sched.out_last  = outLast;
   assign sched.ref_rd_en = refRdEn;
   assign sched.des_rd_en = desRdEn;
   assign busy_o          = (state_q != IDLE);
   assign frame_done_o    = frameDone_q;
   assign skew_err_o      = skewErr_q;

endmodule

// File: tb/tb_lms_fifo_pair_sched.sv
// Scoreboard bench: FIFO models feed the scheduler; expected pairs come from a pairing model of pushed samples.
module tb_lms_fifo_pair_sched;

   localparam int DW = 16;
   localparam int FL = 4;

   typedef struct {
      logic [DW-1:0] r;
      logic [DW-1:0] d;
      bit            last;
   } pair_t;

   logic clk, rst, start, flush, errClr;
   logic busy, frameDone, skewErr;

   lms_fifo_pair_sched_if #(.DW(DW)) bus ();

   lms_fifo_pair_sched #(
      .DATA_WIDTH (DW),
      .FRAME_LEN  (FL),
      .CNT_WIDTH  (2),
      .STALL_MAX  (255),
      .STALL_WIDTH(8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .flush_i     (flush),
      .err_clr_i   (errClr),
      .busy_o      (busy),
      .frame_done_o(frameDone),
      .skew_err_o  (skewErr),
      .sched       (bus)
   );

   pair_t         expQ[$];
   logic [DW-1:0] refQ[$], desQ[$], mRef[$], mDes[$];
   int            pairIdx = 0;
   int            checks = 0;
   int            errors = 0;
   bit            doneExp = 0;
   bit            randRdy = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void updateHeads();
      bus.ref_rd_vld  = (refQ.size() > 0);
      bus.ref_rd_data = (refQ.size() > 0) ? refQ[0] : '0;
      bus.des_rd_vld  = (desQ.size() > 0);
      bus.des_rd_data = (desQ.size() > 0) ? desQ[0] : '0;
   endfunction

   // Reference model: the n-th ref pushed pairs with the n-th des pushed; every FL-th pair ends a frame.
   function automatic void modelPair();
      pair_t p;
      while (mRef.size() > 0 && mDes.size() > 0) begin
         p.r    = mRef.pop_front();
         p.d    = mDes.pop_front();
         p.last = (pairIdx == FL - 1);
         pairIdx = (pairIdx + 1) % FL;
         expQ.push_back(p);
      end
   endfunction

   function automatic void modelClear();
      expQ.delete();
      mRef.delete();
      mDes.delete();
      pairIdx = 0;
   endfunction

   task automatic pushRef(input logic [DW-1:0] r);
      refQ.push_back(r);
      mRef.push_back(r);
      modelPair();
      updateHeads();
   endtask

   task automatic pushDes(input logic [DW-1:0] d);
      desQ.push_back(d);
      mDes.push_back(d);
      modelPair();
      updateHeads();
   endtask

   task automatic applyStimulus(input logic [DW-1:0] r, input logic [DW-1:0] d);
      pushRef(r);
      pushDes(d);
   endtask

   // One clock: capture pops mid-cycle, pop the FIFO models just after the edge; returns at edge+2.
   task automatic tick();
      logic pr, pd;
      @(negedge clk);
      pr = bus.ref_rd_en;
      pd = bus.des_rd_en;
      @(posedge clk);
      #1;
      if (pr && refQ.size() > 0) void'(refQ.pop_front());
      if (pd && desQ.size() > 0) void'(desQ.pop_front());
      updateHeads();
      if (randRdy) bus.out_rdy = 1'($urandom_range(0, 1));
      #1;
   endtask

   task automatic startFrame();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic waitFrameDone(output int n, input int budget);
      bit done;
      done = 0;
      n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
         if (frameDone) done = 1;
      end
      checkOutput("frame_done_seen", 32'(done), 1);
   endtask

   // Monitor: every valid pair is compared with the scoreboard head and popped on handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            doneExp = 0;
         end else begin
            checkOutput("frame_done", 32'(frameDone), 32'(doneExp));
            doneExp = 0;
            if (bus.out_vld) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_pair", expQ.size(), 1);
               end else begin
                  checkOutput("out_ref", 32'(bus.out_ref), 32'(expQ[0].r));
                  checkOutput("out_des", 32'(bus.out_des), 32'(expQ[0].d));
                  checkOutput("out_last", 32'(bus.out_last), 32'(expQ[0].last));
                  if (bus.out_rdy) begin
                     doneExp = expQ[0].last;
                     void'(expQ.pop_front());
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n, sz, k;
      rst = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      errClr = 1'b0;
      bus.out_rdy = 1'b0;
      updateHeads();
      tick();
      tick();
      $display("[TB] reset state");
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_out_vld", 32'(bus.out_vld), 0);
      checkOutput("rst_out_ref", 32'(bus.out_ref), 0);
      checkOutput("rst_ref_rd_en", 32'(bus.ref_rd_en), 0);
      checkOutput("rst_skew_err", 32'(skewErr), 0);
      rst = 1'b0;
      tick();

      $display("[TB] preloaded frame, out_rdy=1");
      bus.out_rdy = 1'b1;
      for (int i = 0; i < FL; i++) applyStimulus(16'($urandom), 16'($urandom));
      startFrame();
      waitFrameDone(n, 50);
      checkOutput("frame1_cycles", n, 5);
      checkOutput("frame1_busy_low", 32'(busy), 0);
      checkOutput("frame1_fifo_empty", refQ.size(), 0);

      $display("[TB] out_rdy stall mid-frame");
      for (int i = 1; i <= FL; i++) applyStimulus(16'(i), 16'(16'h0100 + i));
      startFrame();
      tick();
      tick();
      checkOutput("stall_pre_vld", 32'(bus.out_vld), 1);
      bus.out_rdy = 1'b0;
      sz = refQ.size();
      repeat (5) tick();
      checkOutput("stall_no_pop", refQ.size(), sz);
      checkOutput("stall_vld_held", 32'(bus.out_vld), 1);
      bus.out_rdy = 1'b1;
      waitFrameDone(n, 50);
      checkOutput("stall_all_delivered", expQ.size(), 0);

      $display("[TB] channel skew");
      pushRef(16'($urandom));
      startFrame();
      repeat (250) tick();
      checkOutput("skew_early", 32'(skewErr), 0);
      repeat (50) tick();
      checkOutput("skew_set", 32'(skewErr), 1);
      checkOutput("skew_no_pop", refQ.size(), 1);
      errClr = 1'b1;
      tick();
      errClr = 1'b0;
      checkOutput("skew_cleared", 32'(skewErr), 0);
      pushDes(16'($urandom));
      repeat (4) tick();
      checkOutput("skew_pair_delivered", expQ.size(), 0);

      $display("[TB] flush with pairs queued");
      bus.out_rdy = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(16'($urandom), 16'($urandom));
      repeat (3) tick();
      checkOutput("flush_pre_vld", 32'(bus.out_vld), 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      modelClear();
      checkOutput("flush_vld_dropped", 32'(bus.out_vld), 0);
      k = 0;
      while (busy && k < 20) begin
         tick();
         k++;
      end
      checkOutput("flush_idle", 32'(busy), 0);
      checkOutput("flush_ref_drained", refQ.size(), 0);
      checkOutput("flush_des_drained", desQ.size(), 0);
      bus.out_rdy = 1'b1;

      $display("[TB] reset mid-frame");
      for (int i = 0; i < FL; i++) applyStimulus(16'($urandom), 16'($urandom));
      startFrame();
      tick();
      tick();
      rst = 1'b1;
      #1;
      checkOutput("arst_out_vld", 32'(bus.out_vld), 0);
      checkOutput("arst_busy", 32'(busy), 0);
      checkOutput("arst_out_ref", 32'(bus.out_ref), 0);
      checkOutput("arst_rd_en", 32'(bus.ref_rd_en), 0);
      refQ.delete();
      desQ.delete();
      modelClear();
      updateHeads();
      tick();
      tick();
      rst = 1'b0;
      tick();

      $display("[TB] back-to-back alternating data");
      applyStimulus(16'hAAAA, 16'h5555);
      applyStimulus(16'h5555, 16'hAAAA);
      applyStimulus(16'hAAAA, 16'h5555);
      applyStimulus(16'h5555, 16'hAAAA);
      startFrame();
      waitFrameDone(n, 50);
      checkOutput("b2b_cycles", n, 5);

      $display("[TB] randomized frames");
      randRdy = 1;
      for (int f = 0; f < 6; f++) begin
         applyStimulus(16'($urandom), 16'($urandom));
         applyStimulus(16'($urandom), 16'($urandom));
         startFrame();
         pushRef(16'($urandom));
         pushRef(16'($urandom));
         repeat ($urandom_range(0, 3)) tick();
         pushDes(16'($urandom));
         pushDes(16'($urandom));
         waitFrameDone(n, 200);
         checkOutput("rand_busy_low", 32'(busy), 0);
      end
      randRdy = 0;
      bus.out_rdy = 1'b1;
      repeat (3) tick();
      checkOutput("rand_all_delivered", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
